// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared definitions for the demux dispatch controller: default select width
// and the sequencing FSM state encoding.
package demux_dispatch_ctrl_pkg;

   localparam int SEL_W_DEF = 3;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_DRIVE   = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

endpackage

// File: rtl/demux_dispatch_ctrl_req_fifo.sv
// Request queue for the demux dispatcher: synchronous show-ahead FIFO with
// extra-MSB pointers so full and empty are distinguished without a counter.
module demux_dispatch_ctrl_req_fifo
   import demux_dispatch_ctrl_pkg::*;
#(
   parameter int WIDTH = SEL_W_DEF + 1,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push;
   logic             do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
      // full is judged before any pop, so a pop never frees room for a same-cycle push
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      dout     = mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Demux dispatch controller: queues (channel, bit) requests and sequences the
// demux sel/a/en lines through setup -> drive -> release, with optional sweep.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | en low; pick next request (queue first, then sweep)
//  SETUP   | en low, sel/a settled for one cycle
//  DRIVE   | en high for HOLD_CYC cycles, sel/a frozen
//  RELEASE | en low, done pulse with done_ch = sel
module demux_dispatch_ctrl
   import demux_dispatch_ctrl_pkg::*;
#(
   parameter int SEL_W      = SEL_W_DEF,
   parameter int HOLD_CYC   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [SEL_W-1:0] req_ch,
   input  logic             req_bit,
   input  logic             mode_sweep,
   input  logic             sweep_bit,
   output logic             a,
   output logic             en,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             done,
   output logic [SEL_W-1:0] done_ch
);

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYC - 1);

   state_t           state_q, state_d;
   logic [3:0]       hold_q, hold_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] sweep_q, sweep_d;
   logic [SEL_W-1:0] done_ch_q, done_ch_d;
   logic             a_q, a_d;
   logic             en_q, en_d;
   logic             done_q, done_d;

   logic             fifo_pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [SEL_W:0]   fifo_dout;

   demux_dispatch_ctrl_req_fifo #(
      .WIDTH (SEL_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_req_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (req_valid),
      .pop   (fifo_pop),
      .din   ({req_bit, req_ch}),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      sel_d    = sel_q;
      a_d      = a_q;
      sweep_d  = sweep_q;
      fifo_pop = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               sel_d    = fifo_dout[SEL_W-1:0];
               a_d      = fifo_dout[SEL_W];
               state_d  = ST_SETUP;
            end else if (mode_sweep) begin
               sel_d    = sweep_q;
               a_d      = sweep_bit;
               sweep_d  = sweep_q + SEL_W'(1);
               state_d  = ST_SETUP;
            end
         end
         ST_SETUP: begin
            hold_d  = 4'd0;
            state_d = ST_DRIVE;
         end
         ST_DRIVE: begin
            if (hold_q == HOLD_LAST) begin
               state_d = ST_RELEASE;
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         ST_RELEASE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // strobes are registered from the next state so en/done never glitch on decode
      en_d      = (state_d == ST_DRIVE);
      done_d    = (state_d == ST_RELEASE);
      done_ch_d = done_d ? sel_d : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         hold_q    <= 4'd0;
         sel_q     <= '0;
         a_q       <= 1'b0;
         sweep_q   <= '0;
         en_q      <= 1'b0;
         done_q    <= 1'b0;
         done_ch_q <= '0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         sel_q     <= sel_d;
         a_q       <= a_d;
         sweep_q   <= sweep_d;
         en_q      <= en_d;
         done_q    <= done_d;
         done_ch_q <= done_ch_d;
      end
   end

   assign req_ready = !fifo_full;
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;
   assign a         = a_q;
   assign en        = en_q;
   assign sel       = sel_q;
   assign done      = done_q;
   assign done_ch   = done_ch_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: three instances (HOLD_CYC 2, 1, 15) driving a
// behavioural 1-to-8 demux, checked against a job-timeline reference model.
module tb_demux_dispatch_ctrl;

   localparam int NI    = 3;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic [2:0] req_ch;
   logic       req_bit;
   logic       mode_sweep;
   logic       sweep_bit;

   logic       rdy_w  [NI];
   logic       a_w    [NI];
   logic       en_w   [NI];
   logic       busy_w [NI];
   logic       done_w [NI];
   logic [2:0] sel_w  [NI];
   logic [2:0] dch_w  [NI];
   logic [7:0] dmx_q  [NI];

   int n_vec = 0;
   int n_err = 0;

   // reference model: queue contents plus position t within the current job
   int       m_qch  [NI][DEPTH];
   bit       m_qbit [NI][DEPTH];
   int       m_head [NI];
   int       m_cnt  [NI];
   bit       m_act  [NI];
   int       m_t    [NI];
   int       m_sel  [NI];
   bit       m_a    [NI];
   int       m_sp   [NI];
   bit [7:0] m_out  [NI];

   always #5 clk = ~clk;

   demux_dispatch_ctrl #(.SEL_W(3), .HOLD_CYC(2), .FIFO_DEPTH(DEPTH)) u_dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[0]), .req_ch(req_ch),
      .req_bit(req_bit), .mode_sweep(mode_sweep), .sweep_bit(sweep_bit), .a(a_w[0]),
      .en(en_w[0]), .sel(sel_w[0]), .busy(busy_w[0]), .done(done_w[0]), .done_ch(dch_w[0]));

   demux_dispatch_ctrl #(.SEL_W(3), .HOLD_CYC(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[1]), .req_ch(req_ch),
      .req_bit(req_bit), .mode_sweep(mode_sweep), .sweep_bit(sweep_bit), .a(a_w[1]),
      .en(en_w[1]), .sel(sel_w[1]), .busy(busy_w[1]), .done(done_w[1]), .done_ch(dch_w[1]));

   demux_dispatch_ctrl #(.SEL_W(3), .HOLD_CYC(15), .FIFO_DEPTH(DEPTH)) u_dut2 (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy_w[2]), .req_ch(req_ch),
      .req_bit(req_bit), .mode_sweep(mode_sweep), .sweep_bit(sweep_bit), .a(a_w[2]),
      .en(en_w[2]), .sel(sel_w[2]), .busy(busy_w[2]), .done(done_w[2]), .done_ch(dch_w[2]));

   // the downstream 1-to-8 demux: out[sel] follows a while en is high
   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (rst) dmx_q[k] <= 8'h00;
         else if (en_w[k]) dmx_q[k][sel_w[k]] <= a_w[k];
      end
   end

   function automatic int hold_of(input int k);
      case (k)
         0:       return 2;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   task automatic model_reset(input int k);
      m_head[k] = 0;
      m_cnt[k]  = 0;
      m_act[k]  = 1'b0;
      m_t[k]    = 0;
      m_sel[k]  = 0;
      m_a[k]    = 1'b0;
      m_sp[k]   = 0;
      m_out[k]  = 8'h00;
   endtask

   // one clock edge: job timeline is setup (t=0), drive (t=1..h), release (t=h+1)
   task automatic model_step(input int k, input int h);
      int pre_cnt;
      if (rst) begin
         model_reset(k);
         return;
      end
      pre_cnt = m_cnt[k];
      if (m_act[k] && m_t[k] >= 1 && m_t[k] <= h) m_out[k][m_sel[k]] = m_a[k];
      if (!m_act[k]) begin
         if (m_cnt[k] > 0) begin
            m_sel[k]  = m_qch[k][m_head[k]];
            m_a[k]    = m_qbit[k][m_head[k]];
            m_head[k] = (m_head[k] + 1) % DEPTH;
            m_cnt[k]  = m_cnt[k] - 1;
            m_act[k]  = 1'b1;
            m_t[k]    = 0;
         end else if (mode_sweep) begin
            m_sel[k] = m_sp[k];
            m_a[k]   = sweep_bit;
            m_sp[k]  = (m_sp[k] + 1) % 8;
            m_act[k] = 1'b1;
            m_t[k]   = 0;
         end
      end else begin
         m_t[k] = m_t[k] + 1;
         if (m_t[k] == h + 2) m_act[k] = 1'b0;
      end
      if (req_valid && pre_cnt < DEPTH) begin
         m_qch[k][(m_head[k] + m_cnt[k]) % DEPTH]  = int'(req_ch);
         m_qbit[k][(m_head[k] + m_cnt[k]) % DEPTH] = req_bit;
         m_cnt[k] = m_cnt[k] + 1;
      end
   endtask

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s inst=%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic check_inst(input int k);
      int h;
      bit e_en, e_done;
      h      = hold_of(k);
      e_en   = m_act[k] && m_t[k] >= 1 && m_t[k] <= h;
      e_done = m_act[k] && m_t[k] == h + 1;
      chk("en",        k, 32'(en_w[k]),   32'(e_en));
      chk("sel",       k, 32'(sel_w[k]),  32'(m_sel[k]));
      chk("a",         k, 32'(a_w[k]),    32'(m_a[k]));
      chk("done",      k, 32'(done_w[k]), 32'(e_done));
      chk("done_ch",   k, 32'(dch_w[k]),  e_done ? 32'(m_sel[k]) : 32'd0);
      chk("busy",      k, 32'(busy_w[k]), 32'(m_act[k] || m_cnt[k] > 0));
      chk("req_ready", k, 32'(rdy_w[k]),  32'(m_cnt[k] < DEPTH));
      chk("demux_out", k, 32'(dmx_q[k]),  32'(m_out[k]));
   endtask

   task automatic step_clk();
      @(posedge clk);
      for (int k = 0; k < NI; k++) model_step(k, hold_of(k));
      @(negedge clk);
      for (int k = 0; k < NI; k++) check_inst(k);
   endtask

   initial begin
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_ch     = 3'd0;
      req_bit    = 1'b0;
      mode_sweep = 1'b0;
      sweep_bit  = 1'b0;
      for (int k = 0; k < NI; k++) model_reset(k);
      repeat (2) step_clk();
      rst = 1'b0;
      step_clk();

      // single request ch=5 bit=1
      req_valid = 1'b1; req_ch = 3'd5; req_bit = 1'b1;
      step_clk();
      req_valid = 1'b0;
      repeat (22) step_clk();

      // back-to-back requests ch 0..4
      for (int i = 0; i < 5; i++) begin
         req_valid = 1'b1; req_ch = 3'(i); req_bit = 1'(i);
         step_clk();
      end
      req_valid = 1'b0;
      repeat (100) step_clk();

      // burst while busy so the queue fills and req_ready drops
      req_valid = 1'b1; req_ch = 3'd6; req_bit = 1'b1;
      step_clk();
      for (int i = 0; i < 6; i++) begin
         req_ch = 3'(7 - i); req_bit = 1'(i + 1);
         step_clk();
      end
      req_valid = 1'b0;
      repeat (110) step_clk();

      // sweep with an interleaved queued request
      mode_sweep = 1'b1; sweep_bit = 1'b1;
      repeat (60) step_clk();
      req_valid = 1'b1; req_ch = 3'd2; req_bit = 1'b0;
      step_clk();
      req_valid = 1'b0;
      repeat (150) step_clk();

      // reset while instance 0 is driving, with requests still queued
      sweep_bit = 1'b0;
      req_valid = 1'b1; req_ch = 3'd3; req_bit = 1'b1;
      repeat (3) step_clk();
      req_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (m_act[0] && m_t[0] == 1) break;
         step_clk();
      end
      chk("reach_drive", 0, 32'(m_act[0] && m_t[0] == 1), 32'd1);
      rst = 1'b1; mode_sweep = 1'b0;
      step_clk();
      rst = 1'b0;
      repeat (5) step_clk();

      // randomized traffic with occasional sweep toggles and resets
      for (int i = 0; i < 800; i++) begin
         req_valid = ($urandom_range(0, 9) < 4);
         req_ch    = 3'($urandom_range(0, 7));
         req_bit   = 1'($urandom_range(0, 1));
         sweep_bit = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 49) == 0) mode_sweep = ~mode_sweep;
         rst       = ($urandom_range(0, 299) == 0);
         step_clk();
      end

      rst = 1'b0; req_valid = 1'b0; mode_sweep = 1'b0;
      repeat (40) step_clk();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
